// File: rtl/ps2_scancode_framer_if.sv
// ps2_scancode_framer_if
// Groups the byte-strobe input and the key-event outputs of the PS/2
// scancode framer into one bundle.
//   rx_data / rx_valid      : raw byte strobe from PS2_Controller
//   key_code / key_ext      : code and E0 flag of the last make/break event
//   make_pulse / break_pulse: one-cycle key press / release events
//   key_held / held_code /
//   held_ext                : currently held key as tracked by the framer
//   error_pulse             : one-cycle protocol error or inter-byte timeout
// Modports:
//   master : byte source / event consumer (drives rx_*, reads events)
//   slave  : the framer itself (reads rx_*, drives events)
interface ps2_scancode_framer_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       make_pulse;
  logic       break_pulse;
  logic       key_held;
  logic [7:0] held_code;
  logic       held_ext;
  logic       error_pulse;

  modport master (
    output rx_data, rx_valid,
    input  key_code, key_ext, make_pulse, break_pulse,
    input  key_held, held_code, held_ext, error_pulse
  );

  modport slave (
    input  rx_data, rx_valid,
    output key_code, key_ext, make_pulse, break_pulse,
    output key_held, held_code, held_ext, error_pulse
  );
endinterface

// File: rtl/ps2_scancode_framer.sv
// ps2_scancode_framer
// Parses PS/2 Set-2 byte streams (E0 extended prefix, F0 break prefix,
// E1 pause sequence) into clean one-cycle make/break events, optionally
// suppresses typematic repeats of the held key, and abandons a partial
// prefix sequence if the next byte does not arrive in time.
// Ports:
//   CLOCK_50 : system clock, rising edge
//   reset    : asynchronous, active-high
//   bus      : ps2_scancode_framer_if.slave (byte strobe in, events out)
// All outputs are registered; events appear one cycle after the strobe
// carrying the final byte of a sequence.
module ps2_scancode_framer #(
  parameter int TYPEMATIC_FILTER = 1,
  parameter int TIMEOUT_CYCLES   = 1000000,
  parameter int TW               = 20
) (
  input logic                  CLOCK_50,
  input logic                  reset,
  ps2_scancode_framer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_PAUSE
  } state_t;

  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);
  // Bytes remaining in an E1 pause sequence after the E1 itself.
  localparam logic [2:0]    PAUSE_SKIP = 3'd7;

  state_t          state_reg, state_next;
  logic [TW-1:0]   tmo_reg, tmo_next;
  logic [2:0]      skip_reg, skip_next;
  logic [7:0]      key_code_reg, key_code_next;
  logic            key_ext_reg, key_ext_next;
  logic            make_reg, make_next;
  logic            break_reg, break_next;
  logic            err_reg, err_next;
  logic            held_reg, held_next;
  logic [7:0]      held_code_reg, held_code_next;
  logic            held_ext_reg, held_ext_next;

  logic            do_make;
  logic            do_break;
  logic            ev_ext;
  logic            held_match;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      tmo_reg       <= '0;
      skip_reg      <= '0;
      key_code_reg  <= '0;
      key_ext_reg   <= 1'b0;
      make_reg      <= 1'b0;
      break_reg     <= 1'b0;
      err_reg       <= 1'b0;
      held_reg      <= 1'b0;
      held_code_reg <= '0;
      held_ext_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      tmo_reg       <= tmo_next;
      skip_reg      <= skip_next;
      key_code_reg  <= key_code_next;
      key_ext_reg   <= key_ext_next;
      make_reg      <= make_next;
      break_reg     <= break_next;
      err_reg       <= err_next;
      held_reg      <= held_next;
      held_code_reg <= held_code_next;
      held_ext_reg  <= held_ext_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    tmo_next       = tmo_reg;
    skip_next      = skip_reg;
    key_code_next  = key_code_reg;
    key_ext_next   = key_ext_reg;
    make_next      = 1'b0;
    break_next     = 1'b0;
    err_next       = 1'b0;
    held_next      = held_reg;
    held_code_next = held_code_reg;
    held_ext_next  = held_ext_reg;
    do_make        = 1'b0;
    do_break       = 1'b0;
    ev_ext         = 1'b0;

    if (bus.rx_valid) begin
      // A byte always wins over a timeout expiring in the same cycle.
      tmo_next = '0;
      case (state_reg)
        S_IDLE: begin
          case (bus.rx_data)
            8'hE0: state_next = S_EXT;
            8'hF0: state_next = S_BRK;
            8'hE1: begin
              state_next = S_PAUSE;
              skip_next  = PAUSE_SKIP;
            end
            // Controller replies (BAT ok, ACK, resend, echo, errors).
            8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: ;
            default: do_make = 1'b1;
          endcase
        end
        S_EXT: begin
          case (bus.rx_data)
            8'hF0: state_next = S_EXT_BRK;
            8'hE0: state_next = S_EXT;
            8'hE1: begin
              err_next   = 1'b1;
              state_next = S_PAUSE;
              skip_next  = PAUSE_SKIP;
            end
            default: begin
              do_make    = 1'b1;
              ev_ext     = 1'b1;
              state_next = S_IDLE;
            end
          endcase
        end
        S_BRK: begin
          case (bus.rx_data)
            8'hF0: err_next = 1'b1;
            8'hE0: begin
              err_next   = 1'b1;
              state_next = S_EXT;
            end
            default: begin
              do_break   = 1'b1;
              state_next = S_IDLE;
            end
          endcase
        end
        S_EXT_BRK: begin
          state_next = S_IDLE;
          if (bus.rx_data == 8'hF0 || bus.rx_data == 8'hE0) begin
            err_next = 1'b1;
          end else begin
            do_break = 1'b1;
            ev_ext   = 1'b1;
          end
        end
        S_PAUSE: begin
          skip_next = skip_reg - 3'd1;
          if (skip_reg == 3'd1) begin
            state_next = S_IDLE;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end else if (state_reg == S_IDLE) begin
      tmo_next = '0;
    end else if (tmo_reg == TMO_LAST) begin
      // Truncated sequence: drop the partial prefix.
      err_next   = 1'b1;
      state_next = S_IDLE;
      tmo_next   = '0;
      skip_next  = '0;
    end else begin
      tmo_next = tmo_reg + TMO_ONE;
    end

    held_match = ({ev_ext, bus.rx_data} == {held_ext_reg, held_code_reg});

    if (do_make) begin
      // Typematic repeat of the key already down produces nothing.
      if (!(TYPEMATIC_FILTER != 0 && held_reg && held_match)) begin
        make_next      = 1'b1;
        key_code_next  = bus.rx_data;
        key_ext_next   = ev_ext;
        held_next      = 1'b1;
        held_code_next = bus.rx_data;
        held_ext_next  = ev_ext;
      end
    end

    if (do_break) begin
      break_next    = 1'b1;
      key_code_next = bus.rx_data;
      key_ext_next  = ev_ext;
      // Releasing some other key leaves the tracked key held.
      if (held_match) begin
        held_next = 1'b0;
      end
    end
  end

  assign bus.key_code    = key_code_reg;
  assign bus.key_ext     = key_ext_reg;
  assign bus.make_pulse  = make_reg;
  assign bus.break_pulse = break_reg;
  assign bus.key_held    = held_reg;
  assign bus.held_code   = held_code_reg;
  assign bus.held_ext    = held_ext_reg;
  assign bus.error_pulse = err_reg;

endmodule
